// File: rtl/dcache_mem_req_queue_pkg.sv
// Shared types for the D-cache memory request queue: entry layout, depth,
// index type and drain-phase encoding.
package dcache_mem_req_queue_pkg;

    localparam int MEM_REQ_QUEUE_DEPTH = 4;
    localparam int PHY_ADDR_WIDTH      = 32;
    localparam int DCACHE_LINE_WIDTH   = 128;
    localparam int MEM_SERIAL_WIDTH    = 4;

    typedef logic [$clog2(MEM_REQ_QUEUE_DEPTH)-1:0] MemReqQueueIndexPath;

    // The serial field holds the read serial for reads and the write serial for writes.
    typedef struct packed {
        logic                         we;
        logic [PHY_ADDR_WIDTH-1:0]    addr;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic [MEM_SERIAL_WIDTH-1:0]  serial;
    } MemReqQueueEntry;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        WAIT  = 2'd3
    } MemReqDrainPhase;

endpackage

// File: rtl/dcache_mem_req_queue_fifo.sv
// Circular buffer behind the memory request queue: head/tail pointers,
// entry count and full/empty flags. Depth must be a power of two.
module mem_req_queue_fifo
    import dcache_mem_req_queue_pkg::*;
#(
    parameter int  DEPTH  = MEM_REQ_QUEUE_DEPTH,
    parameter type EntryT = MemReqQueueEntry
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  EntryT                    pushEntry,
    output EntryT                    headEntry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    EntryT            entries [DEPTH];
    logic [IDX_W-1:0] headPtr;
    logic [IDX_W-1:0] tailPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;

    assign headEntry = entries[headPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doPush) tailPtr <= tailPtr + IDX_W'(1);
            if (doPop)  headPtr <= headPtr + IDX_W'(1);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) entries[tailPtr] <= pushEntry;
    end

endmodule

// File: rtl/dcache_mem_req_queue.sv
// D-cache line request queue between the memory-request mux and main memory.
// Optional same-cycle bypass of an empty queue: RSD_DCACHE_MEM_REQ_BYPASS_EN.
module dcache_mem_req_queue
    import dcache_mem_req_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH  = MEM_REQ_QUEUE_DEPTH,
    parameter int ADDR_WIDTH   = PHY_ADDR_WIDTH,
    parameter int LINE_WIDTH   = DCACHE_LINE_WIDTH,
    parameter int SERIAL_WIDTH = MEM_SERIAL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           reqValid,
    input  logic                           reqWE,
    input  logic [ADDR_WIDTH-1:0]          reqAddr,
    input  logic [LINE_WIDTH-1:0]          reqData,
    output logic                           reqAck,
    output logic [SERIAL_WIDTH-1:0]        reqSerial,
    output logic [SERIAL_WIDTH-1:0]        reqWSerial,
    output logic                           memReqValid,
    input  logic                           memReqReady,
    output logic                           memReqWE,
    output logic [ADDR_WIDTH-1:0]          memReqAddr,
    output logic [LINE_WIDTH-1:0]          memReqData,
    output logic [SERIAL_WIDTH-1:0]        memReqSerial,
    output logic [SERIAL_WIDTH-1:0]        memReqWSerial,
    input  logic                           drainReq,
    output logic                           drainDone,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic                    we;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0]   data;
        logic [SERIAL_WIDTH-1:0] serial;
    } EntryT;

    MemReqDrainPhase         state;
    MemReqDrainPhase         nextState;
    logic [SERIAL_WIDTH-1:0] rdCnt;
    logic [SERIAL_WIDTH-1:0] wrCnt;
    logic                    full;
    logic                    empty;
    logic [CNT_W-1:0]        count;
    logic                    accept;
    logic                    bypass;
    logic                    push;
    logic                    pop;
    logic                    emptyAfterPop;
    logic                    issueValid;
    EntryT                   inEntry;
    EntryT                   headEntry;
    EntryT                   issueEntry;

    // Outputs are gated with rst so everything reads 0 while reset is held.
    assign accept  = reqValid & ~full & (state == IDLE) & ~rst;
    assign inEntry = '{we: reqWE, addr: reqAddr, data: reqData,
                       serial: (reqWE ? wrCnt : rdCnt)};

`ifdef RSD_DCACHE_MEM_REQ_BYPASS_EN
    assign bypass = accept & empty & memReqReady;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~bypass;
    assign pop  = ~empty & memReqReady;

    mem_req_queue_fifo #(
        .DEPTH  (QUEUE_DEPTH),
        .EntryT (EntryT)
    ) fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .pushEntry (inEntry),
        .headEntry (headEntry),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign issueEntry = bypass ? inEntry : headEntry;
    assign issueValid = (~empty | bypass) & ~rst;

    assign reqAck        = accept;
    assign reqSerial     = (accept & ~reqWE) ? rdCnt : '0;
    assign reqWSerial    = (accept &  reqWE) ? wrCnt : '0;
    assign memReqValid   = issueValid;
    assign memReqWE      = issueValid & issueEntry.we;
    assign memReqAddr    = issueValid ? issueEntry.addr : '0;
    assign memReqData    = issueValid ? issueEntry.data : '0;
    assign memReqSerial  = (issueValid & ~issueEntry.we) ? issueEntry.serial : '0;
    assign memReqWSerial = (issueValid &  issueEntry.we) ? issueEntry.serial : '0;
    assign occupancy     = count;
    assign drainDone     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdCnt <= '0;
            wrCnt <= '0;
        end else if (accept) begin
            if (reqWE) wrCnt <= wrCnt + SERIAL_WIDTH'(1);
            else       rdCnt <= rdCnt + SERIAL_WIDTH'(1);
        end
    end

    // Finishing the drain one cycle early when the last entry leaves keeps
    // drainDone right behind the final pop instead of an extra idle cycle later.
    assign emptyAfterPop = empty | ((count == CNT_W'(1)) & pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (drainReq) nextState = DRAIN;
            DRAIN: begin
                if (!drainReq)         nextState = IDLE;
                else if (emptyAfterPop) nextState = DONE;
            end
            DONE:    nextState = WAIT;
            WAIT:    if (!drainReq) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_mem_req_queue.sv
// Self-checking bench for dcache_mem_req_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dcache_mem_req_queue;

    localparam int D  = 4;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int SW = 4;
    localparam int CW = 3;
`ifdef RSD_DCACHE_MEM_REQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        int          serial;
    } tbReq_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqValid, reqWE, reqAck, memReqValid, memReqReady, memReqWE;
    logic [AW-1:0] reqAddr, memReqAddr;
    logic [LW-1:0] reqData, memReqData;
    logic [SW-1:0] reqSerial, reqWSerial, memReqSerial, memReqWSerial;
    logic          drainReq, drainDone;
    logic [CW-1:0] occupancy;

    int nChecks = 0;
    int nFails  = 0;
    tbReq_t mq[$];
    int mRd, mWr;

    always #5 clk = ~clk;

    dcache_mem_req_queue dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWE(reqWE), .reqAddr(reqAddr), .reqData(reqData),
        .reqAck(reqAck), .reqSerial(reqSerial), .reqWSerial(reqWSerial),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqWE(memReqWE),
        .memReqAddr(memReqAddr), .memReqData(memReqData),
        .memReqSerial(memReqSerial), .memReqWSerial(memReqWSerial),
        .drainReq(drainReq), .drainDone(drainDone), .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; reqValid = 0; reqWE = 0; reqAddr = '0; reqData = '0;
        memReqReady = 0; drainReq = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete(); mRd = 0; mWr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        reqValid = 1; reqWE = 0;
        for (int i = 0; i < 3; i++) begin reqAddr = 32'h40 * i; tick(); end
        reqValid = 0;
        @(negedge clk);
        nChecks++; if (occupancy !== 3'd3) begin nFails++; $display("FAIL reset_preocc: got %0d want 3", occupancy); end
        #1 rst = 1'b1; reqValid = 1;
        #1;
        nChecks++; if (memReqValid !== 1'b0) begin nFails++; $display("FAIL reset_valid_async: got %0b want 0", memReqValid); end
        nChecks++; if (reqAck !== 1'b0 || reqSerial !== '0 || drainDone !== 1'b0 || memReqAddr !== '0)
            begin nFails++; $display("FAIL reset_outputs: ack %0b ser %0d done %0b addr %h want all 0", reqAck, reqSerial, drainDone, memReqAddr); end
        @(negedge clk);
        nChecks++; if (memReqValid !== 1'b0 || occupancy !== '0)
            begin nFails++; $display("FAIL reset_nextcycle: valid %0b occ %0d want 0 0", memReqValid, occupancy); end
        @(posedge clk); #1 rst = 1'b0; reqValid = 1; reqWE = 0; reqAddr = 32'h80;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b1 || reqSerial !== 4'd0)
            begin nFails++; $display("FAIL reset_first_serial: ack %0b ser %0d want 1 0", reqAck, reqSerial); end
        tick(); reqValid = 0;
        @(negedge clk);
        nChecks++; if (memReqValid !== 1'b1 || memReqSerial !== 4'd0 || occupancy !== 3'd1)
            begin nFails++; $display("FAIL reset_after_issue: valid %0b ser %0d occ %0d want 1 0 1", memReqValid, memReqSerial, occupancy); end
    endtask

    task automatic test_serials();
        bit          weSeq [4]  = '{0, 0, 1, 0};
        int          expSer [4] = '{0, 1, 0, 2};
        logic [AW-1:0] adr [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            adr[i] = $urandom;
            reqValid = 1; reqWE = weSeq[i]; reqAddr = adr[i]; reqData = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            nChecks++;
            if (reqAck !== 1'b1 || reqSerial !== (weSeq[i] ? 4'd0 : 4'(expSer[i])) || reqWSerial !== (weSeq[i] ? 4'(expSer[i]) : 4'd0))
                begin nFails++; $display("FAIL serials_accept%0d: ack %0b rs %0d ws %0d want 1 ser %0d", i, reqAck, reqSerial, reqWSerial, expSer[i]); end
            tick();
        end
        reqValid = 0; memReqReady = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++;
            if (memReqValid !== 1'b1 || memReqWE !== weSeq[i] || memReqAddr !== adr[i] ||
                (weSeq[i] ? memReqWSerial : memReqSerial) !== 4'(expSer[i]))
                begin nFails++; $display("FAIL serials_issue%0d: v %0b we %0b addr %h rs %0d ws %0d want we %0b addr %h ser %0d",
                    i, memReqValid, memReqWE, memReqAddr, memReqSerial, memReqWSerial, weSeq[i], adr[i], expSer[i]); end
            tick();
        end
        @(negedge clk);
        nChecks++; if (memReqValid !== 1'b0) begin nFails++; $display("FAIL serials_empty: valid %0b want 0", memReqValid); end
    endtask

    task automatic test_full();
        do_reset();
        reqValid = 1; reqWE = 0;
        for (int i = 0; i < 4; i++) begin
            reqAddr = 32'h2000 + 32'h40 * i;
            @(negedge clk);
            nChecks++; if (reqAck !== 1'b1) begin nFails++; $display("FAIL full_fill%0d: ack %0b want 1", i, reqAck); end
            tick();
        end
        reqAddr = 32'h2100;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b0 || occupancy !== 3'd4) begin nFails++; $display("FAIL full_block: ack %0b occ %0d want 0 4", reqAck, occupancy); end
        #1 memReqReady = 1;
        #1;
        nChecks++; if (reqAck !== 1'b0) begin nFails++; $display("FAIL full_pop_same_cycle: ack %0b want 0", reqAck); end
        tick(); memReqReady = 0;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b1) begin nFails++; $display("FAIL full_next_accept: ack %0b want 1", reqAck); end
        tick(); reqValid = 0;
        @(negedge clk);
        nChecks++; if (occupancy !== 3'd4 || memReqAddr !== 32'h2040)
            begin nFails++; $display("FAIL full_occ: occ %0d head %h want 4 2040", occupancy, memReqAddr); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int isr[$];
        logic [AW-1:0] iad[$];
        do_reset();
        reqWE = 0;
        for (int cyc = 0; cyc < 200 && isr.size() < 20; cyc++) begin
            reqValid = (sent < 20); reqAddr = 32'h1000 + 32'(sent) * 32'h40;
            memReqReady = ((cyc % 2) == 1);
            @(negedge clk);
            if (reqAck) begin
                nChecks++; if (reqSerial !== 4'(sent % 16))
                    begin nFails++; $display("FAIL wrap_serial%0d: got %0d want %0d", sent, reqSerial, sent % 16); end
                sent++;
            end
            if (memReqValid && memReqReady) begin isr.push_back(int'(memReqSerial)); iad.push_back(memReqAddr); end
            tick();
        end
        nChecks++; if (isr.size() != 20) begin nFails++; $display("FAIL wrap_count: got %0d want 20", isr.size()); end
        for (int i = 0; i < isr.size() && i < 20; i++) begin
            nChecks++; if (isr[i] != (i % 16) || iad[i] !== 32'h1000 + 32'(i) * 32'h40)
                begin nFails++; $display("FAIL wrap_issue%0d: ser %0d addr %h want %0d %h", i, isr[i], iad[i], i % 16, 32'h1000 + 32'(i) * 32'h40); end
        end
        memReqReady = 0;
    endtask

    task automatic test_drain();
        do_reset();
        reqValid = 1; reqWE = 0;
        repeat (2) tick();
        reqValid = 0; drainReq = 1;
        tick();
        reqValid = 1;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b0 || drainDone !== 1'b0 || occupancy !== 3'd2)
            begin nFails++; $display("FAIL drain_block: ack %0b done %0b occ %0d want 0 0 2", reqAck, drainDone, occupancy); end
        tick(); memReqReady = 1;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b0 || memReqValid !== 1'b1 || drainDone !== 1'b0)
            begin nFails++; $display("FAIL drain_pop1: ack %0b valid %0b done %0b want 0 1 0", reqAck, memReqValid, drainDone); end
        tick();
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b0 || drainDone !== 1'b0)
            begin nFails++; $display("FAIL drain_pop2: ack %0b done %0b want 0 0", reqAck, drainDone); end
        tick();
        @(negedge clk);
        nChecks++; if (drainDone !== 1'b1 || occupancy !== 3'd0 || reqAck !== 1'b0)
            begin nFails++; $display("FAIL drain_done: done %0b occ %0d ack %0b want 1 0 0", drainDone, occupancy, reqAck); end
        tick();
        @(negedge clk);
        nChecks++; if (drainDone !== 1'b0 || reqAck !== 1'b0)
            begin nFails++; $display("FAIL drain_pulse_end: done %0b ack %0b want 0 0", drainDone, reqAck); end
        tick(); drainDone_drop: drainReq = 0;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b0) begin nFails++; $display("FAIL drain_wait_hold: ack %0b want 0", reqAck); end
        tick(); memReqReady = 0;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b1 || reqSerial !== 4'd2)
            begin nFails++; $display("FAIL drain_resume: ack %0b ser %0d want 1 2", reqAck, reqSerial); end
        tick();
        // Abort: drainReq falls while entries remain; no drainDone must appear.
        reqValid = 0; drainReq = 1;
        repeat (2) tick();
        drainReq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++; if (drainDone !== 1'b0) begin nFails++; $display("FAIL drain_abort%0d: done %0b want 0", i, drainDone); end
            tick();
        end
        reqValid = 1;
        @(negedge clk);
        nChecks++; if (reqAck !== 1'b1 || occupancy !== 3'd1)
            begin nFails++; $display("FAIL drain_abort_accept: ack %0b occ %0d want 1 1", reqAck, occupancy); end
        tick(); reqValid = 0;
    endtask

    task automatic test_bypass();
        do_reset();
        memReqReady = 1; reqValid = 1; reqWE = 0; reqAddr = 32'h1000;
        @(negedge clk);
`ifdef RSD_DCACHE_MEM_REQ_BYPASS_EN
        nChecks++; if (memReqValid !== 1'b1 || memReqAddr !== 32'h1000 || occupancy !== 3'd0 || memReqSerial !== 4'd0)
            begin nFails++; $display("FAIL bypass_same_cycle: v %0b addr %h occ %0d ser %0d want 1 1000 0 0", memReqValid, memReqAddr, occupancy, memReqSerial); end
        tick(); reqValid = 0;
        @(negedge clk);
        nChecks++; if (memReqValid !== 1'b0 || occupancy !== 3'd0)
            begin nFails++; $display("FAIL bypass_after: v %0b occ %0d want 0 0", memReqValid, occupancy); end
`else
        nChecks++; if (memReqValid !== 1'b0 || reqAck !== 1'b1)
            begin nFails++; $display("FAIL nobypass_same_cycle: v %0b ack %0b want 0 1", memReqValid, reqAck); end
        tick(); reqValid = 0;
        @(negedge clk);
        nChecks++; if (memReqValid !== 1'b1 || memReqAddr !== 32'h1000 || occupancy !== 3'd1)
            begin nFails++; $display("FAIL nobypass_next: v %0b addr %h occ %0d want 1 1000 1", memReqValid, memReqAddr, occupancy); end
`endif
        tick();
        memReqReady = 0;
    endtask

    task automatic test_random();
        bit     expAck, expByp, expValid;
        tbReq_t nw, hd;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            reqValid    = ($urandom_range(0, 9) < 7);
            reqWE       = $urandom_range(0, 1);
            reqAddr     = $urandom;
            reqData     = {$urandom, $urandom, $urandom, $urandom};
            memReqReady = ($urandom_range(0, 9) < 5);
            @(negedge clk);
            nw.we = reqWE; nw.addr = reqAddr; nw.data = reqData; nw.serial = reqWE ? mWr : mRd;
            expAck   = reqValid && (mq.size() < D);
            expByp   = BYPASS && expAck && (mq.size() == 0) && memReqReady;
            expValid = (mq.size() > 0) || expByp;
            hd       = expByp ? nw : ((mq.size() > 0) ? mq[0] : nw);
            nChecks++;
            if (reqAck !== expAck || reqSerial !== ((expAck && !reqWE) ? 4'(mRd) : 4'd0) ||
                reqWSerial !== ((expAck && reqWE) ? 4'(mWr) : 4'd0))
                begin nFails++; $display("FAIL rand_accept c%0d: ack %0b rs %0d ws %0d want %0b rd %0d wr %0d", cyc, reqAck, reqSerial, reqWSerial, expAck, mRd, mWr); end
            nChecks++;
            if (memReqValid !== expValid || occupancy !== CW'(mq.size()))
                begin nFails++; $display("FAIL rand_state c%0d: v %0b occ %0d want %0b %0d", cyc, memReqValid, occupancy, expValid, mq.size()); end
            if (expValid) begin
                nChecks++;
                if (memReqWE !== hd.we || memReqAddr !== hd.addr || memReqData !== hd.data ||
                    memReqSerial !== (hd.we ? 4'd0 : 4'(hd.serial)) || memReqWSerial !== (hd.we ? 4'(hd.serial) : 4'd0))
                    begin nFails++; $display("FAIL rand_head c%0d: we %0b addr %h rs %0d ws %0d want we %0b addr %h ser %0d", cyc, memReqWE, memReqAddr, memReqSerial, memReqWSerial, hd.we, hd.addr, hd.serial); end
            end
            if (mq.size() > 0 && memReqReady) void'(mq.pop_front());
            if (expAck) begin
                if (!expByp) mq.push_back(nw);
                if (nw.we) mWr = (mWr + 1) % 16;
                else       mRd = (mRd + 1) % 16;
            end
            tick();
        end
        reqValid = 0; memReqReady = 0;
    endtask

    initial begin
        test_reset();
        test_serials();
        test_full();
        test_wrap();
        test_drain();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
